// File: rtl/paddle_controller.sv
// paddle_controller: turns encoder detent pulses into a clamped, accelerated
// paddle position and turns the raw encoder switch into a debounced serve pulse.
module paddle_controller #(
  parameter int FIELD_H     = 480,
  parameter int PADDLE_H    = 64,
  parameter int POS_W       = 10,
  parameter int STEP        = 4,
  parameter int FAST_STEP   = 12,
  parameter int FAST_WINDOW = 2_000_000,
  parameter int DEBOUNCE    = 500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             button,
  input  logic             enable,
  input  logic             recenter,
  output logic [POS_W-1:0] paddle_y,
  output logic             moved,
  output logic             serve
);

  localparam int MAX_Y  = FIELD_H - PADDLE_H;
  localparam int CENTER = MAX_Y / 2;
  localparam int WIDE_W = POS_W + 1;
  localparam int GAP_W  = $clog2(FAST_WINDOW + 1);
  localparam int CNT_W  = $clog2(DEBOUNCE);

  localparam logic [POS_W-1:0]  CENTER_P = POS_W'(CENTER);
  localparam logic [POS_W-1:0]  MAX_P    = POS_W'(MAX_Y);
  localparam logic [WIDE_W-1:0] MAX_WIDE = WIDE_W'(MAX_Y);
  localparam logic [WIDE_W-1:0] STEP_W   = WIDE_W'(STEP);
  localparam logic [WIDE_W-1:0] FAST_W   = WIDE_W'(FAST_STEP);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(FAST_WINDOW);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);

  // Button debounce states
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Position path state
  logic [POS_W-1:0]  pos_reg, pos_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic              last_up_reg, last_up_next;
  logic              moved_reg;

  // Button path state
  logic [1:0]        sync_reg;
  logic              bs;
  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              serve_reg, serve_next;

  // Position datapath helpers
  logic              detent_ok;
  logic [WIDE_W-1:0] pos_wide;
  logic [WIDE_W-1:0] step_w;
  logic [WIDE_W-1:0] sum_wide;

  assign paddle_y = pos_reg;
  assign moved    = moved_reg;
  assign serve    = serve_reg;
  assign bs       = sync_reg[1];

  // Next paddle position: recenter wins, then a single-direction detent,
  // otherwise the inter-detent gap counter keeps aging toward saturation.
  always_comb begin
    pos_next     = pos_reg;
    gap_next     = gap_reg;
    last_up_next = last_up_reg;
    detent_ok    = enable & (up ^ down);
    pos_wide     = {1'b0, pos_reg};
    step_w       = ((up == last_up_reg) && (gap_reg < GAP_MAX)) ? FAST_W : STEP_W;
    sum_wide     = pos_wide + step_w;
    if (recenter) begin
      pos_next = CENTER_P;
      gap_next = GAP_MAX;
    end else if (detent_ok) begin
      gap_next     = '0;
      last_up_next = up;
      if (up) begin
        // Compare before subtracting so the top edge clamps at 0 without wrapping
        pos_next = (pos_wide >= step_w) ? POS_W'(pos_wide - step_w) : '0;
      end else begin
        pos_next = (sum_wide > MAX_WIDE) ? MAX_P : POS_W'(sum_wide);
      end
    end else if (gap_reg < GAP_MAX) begin
      gap_next = gap_reg + GAP_W'(1);
    end
  end

  // Position, acceleration history and move strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg     <= CENTER_P;
      gap_reg     <= GAP_MAX;
      last_up_reg <= 1'b1;
      moved_reg   <= 1'b0;
    end else begin
      pos_reg     <= pos_next;
      gap_reg     <= gap_next;
      last_up_reg <= last_up_next;
      moved_reg   <= (pos_next != pos_reg);
    end
  end

  // Two-flop synchroniser for the asynchronous switch level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], button};
    end
  end

  // Debounce FSM: a level must hold DEBOUNCE synchronised samples to be
  // believed; serve fires only on the press transition.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    serve_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bs) begin
          state_next = ST_PRESS_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!bs) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_PRESSED;
          serve_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!bs) begin
          state_next = ST_RELEASE_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      default: begin
        if (bs) begin
          state_next = ST_PRESSED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    endcase
  end

  // Debounce state, counter and serve pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      serve_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      serve_reg <= serve_next;
    end
  end

endmodule

// File: tb/tb_paddle_controller.sv
// tb_paddle_controller: directed scenarios followed by random stimulus, every
// cycle compared against a behavioural model of the paddle and serve rules.
module tb_paddle_controller;

  localparam int FIELD_H     = 100;
  localparam int PADDLE_H    = 20;
  localparam int POS_W       = 10;
  localparam int STEP        = 4;
  localparam int FAST_STEP   = 10;
  localparam int FAST_WINDOW = 8;
  localparam int DEBOUNCE    = 4;
  localparam int MAX_Y       = FIELD_H - PADDLE_H;
  localparam int CENTER      = MAX_Y / 2;
  localparam int BIG         = 1_000_000;

  logic             clk = 1'b0;
  logic             rst;
  logic             up, down, button, enable, recenter;
  logic [POS_W-1:0] paddle_y;
  logic             moved, serve;

  paddle_controller #(
    .FIELD_H(FIELD_H), .PADDLE_H(PADDLE_H), .POS_W(POS_W), .STEP(STEP),
    .FAST_STEP(FAST_STEP), .FAST_WINDOW(FAST_WINDOW), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .button(button),
    .enable(enable), .recenter(recenter),
    .paddle_y(paddle_y), .moved(moved), .serve(serve)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // Behavioural model: position, direction history as "edges since last detent",
  // button history as a sample delay line plus run lengths of the level.
  int m_y, m_since, hi_run, lo_run;
  bit m_last_up, m_moved, m_serve, pressed;
  bit hist [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_y = CENTER; m_since = BIG; m_last_up = 1'b1;
    m_moved = 1'b0; m_serve = 1'b0;
    hist[0] = 1'b0; hist[1] = 1'b0;
    hi_run = 0; lo_run = 0; pressed = 1'b0;
  endtask

  task automatic model_edge(input bit u, input bit d, input bit b, input bit en, input bit rc);
    int old_y;
    int stp;
    bit bsv;
    old_y = m_y;
    if (m_since < BIG) m_since++;
    if (rc) begin
      m_y = CENTER;
      m_since = BIG;
    end else if (en && (u != d)) begin
      stp = (m_last_up == u && m_since <= FAST_WINDOW) ? FAST_STEP : STEP;
      if (u) m_y = (m_y - stp < 0) ? 0 : m_y - stp;
      else   m_y = (m_y + stp > MAX_Y) ? MAX_Y : m_y + stp;
      m_last_up = u;
      m_since = 0;
    end
    m_moved = (m_y != old_y);
    // The debouncer sees the switch level sampled two edges earlier
    bsv = hist[1];
    hist[1] = hist[0];
    hist[0] = b;
    m_serve = 1'b0;
    if (bsv) begin hi_run++; lo_run = 0; end
    else     begin lo_run++; hi_run = 0; end
    if (!pressed && hi_run == DEBOUNCE) begin
      pressed = 1'b1;
      m_serve = 1'b1;
    end else if (pressed && lo_run == DEBOUNCE) begin
      pressed = 1'b0;
    end
  endtask

  task automatic tick(input bit u, input bit d, input bit b, input bit en, input bit rc);
    up = u; down = d; button = b; enable = en; recenter = rc;
    @(posedge clk);
    model_edge(u, d, b, en, rc);
    #1;
    chk("paddle_y", paddle_y, m_y);
    chk("moved", moved, m_moved);
    chk("serve", serve, m_serve);
    $display("[%0t] %s up=%0b dn=%0b btn=%0b en=%0b rc=%0b -> y=%0d moved=%0b serve=%0b",
             $time, phase, u, d, b, en, rc, paddle_y, moved, serve);
  endtask

  task automatic idle(input int n, input bit b);
    repeat (n) tick(1'b0, 1'b0, b, 1'b1, 1'b0);
  endtask

  // Async reset pulse placed between clock edges; outputs must drop at once
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_y", paddle_y, CENTER);
    chk("async_rst_moved", moved, 0);
    chk("async_rst_serve", serve, 0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  // Hold the switch at a level for n edges, reporting serve count and first index
  task automatic hold_button(input int n, input bit b, output int cnt, output int first);
    cnt = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, b, 1'b1, 1'b0);
      if (serve === 1'b1) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
  endtask

  initial begin
    int sc, sf;
    bit btn, u, d, en, rc;
    rst = 1'b1; up = 0; down = 0; button = 0; enable = 1; recenter = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_y", paddle_y, CENTER);
    chk("reset_moved", moved, 0);
    chk("reset_serve", serve, 0);
    #1 rst = 1'b0;
    model_reset();

    phase = "accel";
    tick(1, 0, 0, 1, 0); chk("first_up", paddle_y, 36); chk("first_up_moved", moved, 1);
    idle(2, 0);
    tick(1, 0, 0, 1, 0); chk("fast_up", paddle_y, 26);
    tick(0, 1, 0, 1, 0); chk("dir_change_slow", paddle_y, 30);
    idle(9, 0);
    tick(0, 1, 0, 1, 0); chk("window_expired", paddle_y, 34);
    idle(7, 0);
    tick(0, 1, 0, 1, 0); chk("window_edge_fast", paddle_y, 44);
    idle(8, 0);
    tick(0, 1, 0, 1, 0); chk("window_edge_slow", paddle_y, 48);

    phase = "clamp";
    tick(0, 0, 0, 1, 1); chk("recenter", paddle_y, 40);
    repeat (5) tick(0, 1, 0, 1, 0);
    chk("reach_max", paddle_y, 80);
    tick(0, 1, 0, 1, 0); chk("max_hold", paddle_y, 80); chk("max_no_move", moved, 0);
    repeat (8) tick(1, 0, 0, 1, 0);
    chk("reach_6", paddle_y, 6);
    idle(9, 0);
    tick(1, 0, 0, 1, 0); chk("slow_to_2", paddle_y, 2);
    tick(1, 0, 0, 1, 0); chk("clamp_0", paddle_y, 0);
    tick(1, 0, 0, 1, 0); chk("zero_hold", paddle_y, 0); chk("zero_no_move", moved, 0);

    phase = "conflict";
    idle(9, 0);
    tick(0, 1, 0, 1, 0); chk("down_4", paddle_y, 4);
    tick(1, 1, 0, 1, 0); chk("both_ignored", paddle_y, 4); chk("both_no_move", moved, 0);
    tick(0, 1, 0, 0, 0); chk("disabled", paddle_y, 4); chk("disabled_no_move", moved, 0);
    repeat (4) tick(0, 1, 0, 1, 0);
    repeat (4) begin idle(9, 0); tick(0, 1, 0, 1, 0); end
    chk("reach_60", paddle_y, 60);
    tick(0, 1, 0, 1, 1); chk("recenter_wins", paddle_y, 40); chk("recenter_moved", moved, 1);

    phase = "reset_mid";
    tick(0, 1, 0, 1, 0);
    repeat (2) tick(0, 1, 0, 1, 0);
    repeat (2) begin idle(9, 0); tick(0, 1, 0, 1, 0); end
    chk("reach_72", paddle_y, 72);
    pulse_reset();

    phase = "button";
    hold_button(10, 1, sc, sf);
    chk("press_count", sc, 1); chk("press_index", sf, 5);
    hold_button(6, 0, sc, sf);  chk("release_no_serve", sc, 0);
    hold_button(3, 1, sc, sf);  chk("glitch_high", sc, 0);
    hold_button(6, 0, sc, sf);  chk("glitch_tail", sc, 0);
    hold_button(8, 1, sc, sf);  chk("repress_count", sc, 1);
    hold_button(6, 0, sc, sf);  chk("rerelease", sc, 0);
    hold_button(3, 1, sc, sf);  chk("pre_reset_wait", sc, 0);
    pulse_reset();
    hold_button(8, 1, sc, sf);
    chk("post_reset_count", sc, 1); chk("post_reset_index", sf, 5);
    hold_button(6, 0, sc, sf);  chk("post_reset_release", sc, 0);

    phase = "random";
    btn = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) btn = ~btn;
      u  = ($urandom_range(0, 99) < 20);
      d  = ($urandom_range(0, 99) < 20);
      en = ($urandom_range(0, 99) < 85);
      rc = ($urandom_range(0, 99) < 3);
      tick(u, d, btn, en, rc);
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
